// File: rtl/proc_result_checker.sv
// rtl/proc_result_checker.sv - self-check harness that runs singlecycle against a list of {end PC, pass code} entries
//
// Purpose:
//   Holds the processor in reset until started, then for each check entry
//   waits for currentpc >= endpc, lets one settle cycle pass and compares
//   dmemout against the expected pass code. Counts passes and aborts the run
//   when a cycle watchdog reaches WATCHDOG_MAX.
//
// Ports:
//   CLK, reset        clock (rising edge), asynchronous active-high reset
//   start             run start pulse, honoured only in IDLE/DONE
//   currentpc/dmemout observed processor PC and data-memory read data
//   check_*           entry stream: endpc, expected code, valid; ready = consumed
//   proc_resetl       active-low reset driven to the processor
//   startpc           constant START_PC
//   check_idx         entry in progress or last completed
//   pass_count        entries passed in this run
//   busy/done         run in progress / run finished (sticky until next start)
//   all_passed        done with every entry passing
//   wd_expired        run aborted by the watchdog (sticky until next start)
//
// Build option:
//   FAIL_CAPTURE_EN   adds fail_seen/fail_idx/fail_actual capturing the first
//                     mismatch of a run (sticky until next start).

module proc_result_checker #(
  parameter int          NUM_CHECKS   = 2,
  parameter logic [15:0] WATCHDOG_MAX = 16'h00FF,
  parameter logic [63:0] START_PC     = 64'h0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] currentpc,
  input  logic [63:0] dmemout,
  input  logic [63:0] check_endpc,
  input  logic [63:0] check_expected,
  input  logic        check_valid,
  output logic        check_ready,
  output logic        proc_resetl,
  output logic [63:0] startpc,
  output logic [7:0]  check_idx,
  output logic [7:0]  pass_count,
  output logic        busy,
  output logic        done,
  output logic        all_passed,
  output logic        wd_expired
`ifdef FAIL_CAPTURE_EN
  ,
  output logic        fail_seen,
  output logic [7:0]  fail_idx,
  output logic [63:0] fail_actual
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_PRST, S_LOAD, S_RUN, S_SETTLE, S_DONE} state_t;

  localparam logic [7:0] LAST_IDX     = 8'(NUM_CHECKS - 1);
  localparam logic [7:0] NUM_CHECKS_8 = 8'(NUM_CHECKS);

  state_t      r_state;
  logic [63:0] r_endpc;
  logic [63:0] r_expected;
  logic [7:0]  r_check_idx;
  logic [7:0]  r_pass_count;
  logic        r_done;
  logic        r_all_passed;
  logic        r_wd_expired;
  logic [15:0] r_watchdog;
`ifdef FAIL_CAPTURE_EN
  logic        r_fail_seen;
  logic [7:0]  r_fail_idx;
  logic [63:0] r_fail_actual;
`endif

  logic        w_active;
  logic [15:0] w_wd_next;
  logic        w_wd_hit;
  logic        w_match;
  logic [7:0]  w_pass_next;

  assign w_active    = (r_state == S_PRST) || (r_state == S_LOAD) ||
                       (r_state == S_RUN)  || (r_state == S_SETTLE);
  assign w_wd_next   = (r_watchdog == 16'hFFFF) ? r_watchdog : r_watchdog + 16'd1;
  // Expiry is judged on the count this edge produces, so a run is aborted
  // after exactly WATCHDOG_MAX busy cycles.
  assign w_wd_hit    = w_active && (w_wd_next >= WATCHDOG_MAX);
  assign w_match     = (dmemout == r_expected);
  assign w_pass_next = r_pass_count + {7'd0, w_match};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_endpc      <= 64'd0;
      r_expected   <= 64'd0;
      r_check_idx  <= 8'd0;
      r_pass_count <= 8'd0;
      r_done       <= 1'b0;
      r_all_passed <= 1'b0;
      r_wd_expired <= 1'b0;
      r_watchdog   <= 16'd0;
`ifdef FAIL_CAPTURE_EN
      r_fail_seen   <= 1'b0;
      r_fail_idx    <= 8'd0;
      r_fail_actual <= 64'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_PRST;
            r_check_idx  <= 8'd0;
            r_pass_count <= 8'd0;
            r_done       <= 1'b0;
            r_all_passed <= 1'b0;
            r_wd_expired <= 1'b0;
            r_watchdog   <= 16'd0;
`ifdef FAIL_CAPTURE_EN
            r_fail_seen   <= 1'b0;
            r_fail_idx    <= 8'd0;
            r_fail_actual <= 64'd0;
`endif
          end
        end
        default: begin
          r_watchdog <= w_wd_next;
          if (w_wd_hit) begin
            // Watchdog overrides everything, including a SETTLE compare.
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_all_passed <= 1'b0;
            r_wd_expired <= 1'b1;
          end else begin
            case (r_state)
              S_PRST: r_state <= S_LOAD;
              S_LOAD: begin
                if (check_valid) begin
                  r_endpc    <= check_endpc;
                  r_expected <= check_expected;
                  r_state    <= S_RUN;
                end
              end
              S_RUN: begin
                if (currentpc >= r_endpc) r_state <= S_SETTLE;
              end
              S_SETTLE: begin
                r_pass_count <= w_pass_next;
`ifdef FAIL_CAPTURE_EN
                if (!w_match && !r_fail_seen) begin
                  r_fail_seen   <= 1'b1;
                  r_fail_idx    <= r_check_idx;
                  r_fail_actual <= dmemout;
                end
`endif
                if (r_check_idx == LAST_IDX) begin
                  r_state      <= S_DONE;
                  r_done       <= 1'b1;
                  r_all_passed <= (w_pass_next == NUM_CHECKS_8);
                end else begin
                  r_check_idx <= r_check_idx + 8'd1;
                  r_state     <= S_LOAD;
                end
              end
              default: r_state <= r_state;
            endcase
          end
        end
      endcase
    end
  end

  assign check_ready = (r_state == S_LOAD);
  assign proc_resetl = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_SETTLE);
  assign busy        = w_active;
  assign startpc     = START_PC;
  assign check_idx   = r_check_idx;
  assign pass_count  = r_pass_count;
  assign done        = r_done;
  assign all_passed  = r_all_passed;
  assign wd_expired  = r_wd_expired;
`ifdef FAIL_CAPTURE_EN
  assign fail_seen   = r_fail_seen;
  assign fail_idx    = r_fail_idx;
  assign fail_actual = r_fail_actual;
`endif

endmodule
